// File: rtl/sha256_msg_padder_if.sv
// Bundle between the message padder, its message memory and the downstream
// SHA-256 compression core.
interface sha256_msg_padder_if;
  logic              start;
  logic [15:0]       message_addr;
  logic [15:0]       mem_addr;
  logic              mem_re;
  logic [31:0]       mem_read_data;
  logic              blk_valid;
  logic              blk_ready;
  logic [15:0][31:0] blk_data;
  logic [7:0]        blk_index;
  logic              blk_last;
  logic              busy;
  logic              done;

  modport master (
    input  start, message_addr, mem_read_data, blk_ready,
    output mem_addr, mem_re, blk_valid, blk_data, blk_index, blk_last, busy, done
  );

  modport slave (
    output start, message_addr, mem_read_data, blk_ready,
    input  mem_addr, mem_re, blk_valid, blk_data, blk_index, blk_last, busy, done
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// Streams a fixed-length message from word memory and emits SHA-256 padded
// 512-bit blocks over a valid/ready handshake.
module sha256_msg_padder #(
  parameter int NUM_OF_WORDS = 20
) (
  input logic               clk,
  input logic               reset,
  sha256_msg_padder_if.master bus
);
  localparam int          NUM_BLOCKS = (NUM_OF_WORDS + 18) / 16;
  localparam logic [15:0] MSG_WORDS  = 16'(NUM_OF_WORDS);
  localparam logic [15:0] LEN_IDX    = 16'(16 * NUM_BLOCKS - 1);
  localparam logic [31:0] BIT_LEN    = 32'(NUM_OF_WORDS * 32);
  localparam logic [7:0]  LAST_BLK   = 8'(NUM_BLOCKS - 1);

  typedef enum logic [1:0] {IDLE, FILL, PRESENT, FINISH} state_t;

  state_t      state_reg;
  logic [15:0] base_addr_reg;
  logic [15:0] word_base_reg;
  logic [4:0]  fill_cnt_reg;
  logic [15:0] mem_addr_reg;
  logic        mem_re_reg;
  logic        blk_valid_reg;
  logic [7:0]  blk_index_reg;
  logic        blk_last_reg;
  logic        busy_reg;
  logic        done_reg;

  logic [15:0] wr_g;
  logic [15:0] rd_g;
  logic [15:0] next_base;
  logic [31:0] wr_word;

  // In FILL cycle k the word k-1 is captured while word k+1 is requested.
  assign wr_g      = word_base_reg + 16'(fill_cnt_reg) - 16'd1;
  assign rd_g      = word_base_reg + 16'(fill_cnt_reg) + 16'd1;
  assign next_base = word_base_reg + 16'd16;

  always_comb begin
    wr_word = 32'h0;
    if (wr_g < MSG_WORDS)
      wr_word = bus.mem_read_data;
    else if (wr_g == MSG_WORDS)
      wr_word = 32'h8000_0000;
    else if (wr_g == LEN_IDX)
      wr_word = BIT_LEN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      base_addr_reg <= '0;
      word_base_reg <= '0;
      fill_cnt_reg  <= '0;
      mem_addr_reg  <= '0;
      mem_re_reg    <= 1'b0;
      blk_valid_reg <= 1'b0;
      blk_index_reg <= '0;
      blk_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      mem_re_reg <= 1'b0;
      done_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg     <= FILL;
            base_addr_reg <= bus.message_addr;
            word_base_reg <= '0;
            fill_cnt_reg  <= '0;
            blk_index_reg <= '0;
            busy_reg      <= 1'b1;
            // Word 0 is always message data since the message is never empty.
            mem_re_reg    <= 1'b1;
            mem_addr_reg  <= bus.message_addr;
          end
        end
        FILL: begin
          fill_cnt_reg <= fill_cnt_reg + 5'd1;
          if (fill_cnt_reg < 5'd15 && rd_g < MSG_WORDS) begin
            mem_re_reg   <= 1'b1;
            mem_addr_reg <= base_addr_reg + rd_g;
          end
          if (fill_cnt_reg == 5'd16) begin
            state_reg     <= PRESENT;
            blk_valid_reg <= 1'b1;
            blk_last_reg  <= (blk_index_reg == LAST_BLK);
          end
        end
        PRESENT: begin
          if (bus.blk_ready) begin
            blk_valid_reg <= 1'b0;
            blk_last_reg  <= 1'b0;
            if (blk_last_reg) begin
              state_reg <= FINISH;
              done_reg  <= 1'b1;
            end else begin
              state_reg     <= FILL;
              blk_index_reg <= blk_index_reg + 8'd1;
              word_base_reg <= next_base;
              fill_cnt_reg  <= '0;
              if (next_base < MSG_WORDS) begin
                mem_re_reg   <= 1'b1;
                mem_addr_reg <= base_addr_reg + next_base;
              end
            end
          end
        end
        FINISH: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // One register per block word; only written during FILL, so the buffer
  // cannot change while a block is being presented.
  for (genvar gi = 0; gi < 16; gi++) begin : g_word
    logic [31:0] word_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        word_reg <= '0;
      else if (state_reg == FILL && fill_cnt_reg == 5'(gi + 1))
        word_reg <= wr_word;
    end

    assign bus.blk_data[gi] = word_reg;
  end

  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_re    = mem_re_reg;
  assign bus.blk_valid = blk_valid_reg;
  assign bus.blk_index = blk_index_reg;
  assign bus.blk_last  = blk_last_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: several message lengths side by side,
// scoreboard of expected padded blocks checked at each handshake.
module tb_sha256_msg_padder;
  localparam int NI = 5;
  localparam int NW [NI] = '{20, 13, 14, 16, 4};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              start_a [NI];
  logic [15:0]       addr_a  [NI];
  logic              ready_a [NI];
  logic              valid_a [NI];
  logic              last_a  [NI];
  logic              busy_a  [NI];
  logic              done_a  [NI];
  logic              re_a    [NI];
  logic [15:0]       maddr_a [NI];
  logic [7:0]        idx_a   [NI];
  logic [15:0][31:0] data_a  [NI];
  int                re_cnt_a   [NI];
  int                done_cnt_a [NI];

  typedef struct {
    logic [7:0]        idx;
    logic              last;
    logic [15:0][31:0] w;
  } blk_t;

  blk_t sbq[$];
  int total = 0;
  int bad = 0;
  logic [31:0] last_w0, last_w15;

  function automatic logic [31:0] memf(input logic [15:0] a);
    return 32'(a) - 32'h100;
  endfunction

  function automatic logic [31:0] exp_word(input int nw, input logic [15:0] base,
                                           input int g, input int nb);
    if (g < nw) return memf(base + 16'(g));
    if (g == nw) return 32'h8000_0000;
    if (g == 16 * nb - 1) return 32'(nw * 32);
    return 32'h0;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    sha256_msg_padder_if bif();
    logic [31:0] rdata = '0;
    int          re_cnt = 0;
    int          done_cnt = 0;
    logic [15:0] addr_log [64];

    sha256_msg_padder #(.NUM_OF_WORDS(NW[gi])) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.master)
    );

    assign bif.start         = start_a[gi];
    assign bif.message_addr  = addr_a[gi];
    assign bif.blk_ready     = ready_a[gi];
    assign bif.mem_read_data = rdata;
    assign valid_a[gi]    = bif.blk_valid;
    assign last_a[gi]     = bif.blk_last;
    assign busy_a[gi]     = bif.busy;
    assign done_a[gi]     = bif.done;
    assign re_a[gi]       = bif.mem_re;
    assign maddr_a[gi]    = bif.mem_addr;
    assign idx_a[gi]      = bif.blk_index;
    assign data_a[gi]     = bif.blk_data;
    assign re_cnt_a[gi]   = re_cnt;
    assign done_cnt_a[gi] = done_cnt;

    always @(posedge clk) begin
      if (bif.mem_re) begin
        rdata <= memf(bif.mem_addr);
        addr_log[re_cnt % 64] <= bif.mem_addr;
        re_cnt <= re_cnt + 1;
      end
      if (bif.done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for blk_valid on instance d; returns cycles waited.
  task automatic wait_valid(input int d, input bit glitch, input bit first, output int n);
    n = 0;
    while (!valid_a[d] && n < 40) begin
      tick();
      n++;
      if (glitch && first && n == 3) begin
        start_a[d] = 1'b1;
        addr_a[d]  = 16'h0500;
      end else begin
        start_a[d] = 1'b0;
      end
      if (glitch) ready_a[d] = 1'b1;
    end
  endtask

  task automatic handshake(input int d, input int b);
    blk_t e;
    ready_a[d] = 1'b1;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 32'(sbq.size()), 32'd1);
    end else begin
      e = sbq.pop_front();
      chk($sformatf("n%0d_b%0d_index", NW[d], b), 32'(idx_a[d]), 32'(e.idx));
      chk($sformatf("n%0d_b%0d_last", NW[d], b), 32'(last_a[d]), 32'(e.last));
      for (int k = 0; k < 16; k++)
        chk($sformatf("n%0d_b%0d_w%0d", NW[d], b, k), data_a[d][k], e.w[k]);
    end
    last_w0  = data_a[d][0];
    last_w15 = data_a[d][15];
    $display("n=%0d block %0d index=%0d last=%0d w0=%08h w15=%08h",
             NW[d], b, idx_a[d], last_a[d], data_a[d][0], data_a[d][15]);
    tick();
    ready_a[d] = 1'b0;
    chk("valid_drop", 32'(valid_a[d]), 32'd0);
  endtask

  task automatic run_msg(input int d, input logic [15:0] addr, input int hold, input bit glitch);
    int nb, rc0, rc1, dc0, n;
    blk_t e;
    nb = (NW[d] + 18) / 16;
    sbq.delete();
    for (int b = 0; b < nb; b++) begin
      e.idx  = 8'(b);
      e.last = (b == nb - 1);
      for (int k = 0; k < 16; k++) e.w[k] = exp_word(NW[d], addr, 16 * b + k, nb);
      sbq.push_back(e);
    end
    rc0 = re_cnt_a[d];
    dc0 = done_cnt_a[d];
    start_a[d] = 1'b1;
    addr_a[d]  = addr;
    tick();
    start_a[d] = 1'b0;
    chk("busy_after_start", 32'(busy_a[d]), 32'd1);
    for (int b = 0; b < nb; b++) begin
      wait_valid(d, glitch, b == 0, n);
      chk($sformatf("n%0d_b%0d_latency", NW[d], b), 32'(n), 32'd17);
      if (hold > 0) begin
        rc1 = re_cnt_a[d];
        for (int h = 0; h < hold; h++) begin
          tick();
          chk("bp_valid", 32'(valid_a[d]), 32'd1);
          chk("bp_index", 32'(idx_a[d]), 32'(b));
        end
        chk("bp_no_mem_re", 32'(re_cnt_a[d] - rc1), 32'd0);
      end
      handshake(d, b);
    end
    chk("done_pulse", 32'(done_a[d]), 32'd1);
    chk("busy_in_finish", 32'(busy_a[d]), 32'd1);
    tick();
    chk("done_fall", 32'(done_a[d]), 32'd0);
    chk("busy_fall", 32'(busy_a[d]), 32'd0);
    chk("mem_re_count", 32'(re_cnt_a[d] - rc0), 32'(NW[d]));
    chk("done_count", 32'(done_cnt_a[d] - dc0), 32'd1);
  endtask

  initial begin
    int rc0, dc0, n;
    for (int i = 0; i < NI; i++) begin
      start_a[i] = 1'b0;
      addr_a[i]  = 16'h0;
      ready_a[i] = 1'b0;
    end
    tick();
    tick();
    chk("rst_valid", 32'(valid_a[0]), 32'd0);
    chk("rst_busy", 32'(busy_a[0]), 32'd0);
    chk("rst_mem_re", 32'(re_a[0]), 32'd0);
    chk("rst_mem_addr", 32'(maddr_a[0]), 32'd0);
    chk("rst_index", 32'(idx_a[0]), 32'd0);
    chk("rst_done", 32'(done_a[0]), 32'd0);
    reset = 1'b0;
    tick();

    // Basic two-block message, then back-to-back runs with backpressure and
    // with ignored start/address changes while busy.
    run_msg(0, 16'h0100, 0, 1'b0);
    chk("n20_len_word", last_w15, 32'h0000_0280);
    run_msg(0, 16'h0100, 10, 1'b0);
    run_msg(0, 16'h0100, 0, 1'b1);
    chk("glitch_len_word", last_w15, 32'h0000_0280);

    run_msg(1, 16'h0100, 0, 1'b0);
    chk("n13_len_word", last_w15, 32'h0000_01A0);
    run_msg(2, 16'h0100, 0, 1'b0);
    chk("n14_len_word", last_w15, 32'h0000_01C0);
    run_msg(3, 16'h0100, 0, 1'b0);
    chk("n16_marker", last_w0, 32'h8000_0000);
    chk("n16_len_word", last_w15, 32'h0000_0200);

    rc0 = re_cnt_a[4];
    run_msg(4, 16'hFFFE, 0, 1'b0);
    chk("wrap_addr0", 32'(g_dut[4].addr_log[(rc0 + 0) % 64]), 32'h0000_FFFE);
    chk("wrap_addr1", 32'(g_dut[4].addr_log[(rc0 + 1) % 64]), 32'h0000_FFFF);
    chk("wrap_addr2", 32'(g_dut[4].addr_log[(rc0 + 2) % 64]), 32'h0000_0000);
    chk("wrap_addr3", 32'(g_dut[4].addr_log[(rc0 + 3) % 64]), 32'h0000_0001);

    // Reset in the middle of filling the second block.
    dc0 = done_cnt_a[0];
    sbq.delete();
    start_a[0] = 1'b1;
    addr_a[0]  = 16'h0100;
    tick();
    start_a[0] = 1'b0;
    wait_valid(0, 1'b0, 1'b1, n);
    chk("rst_test_latency", 32'(n), 32'd17);
    ready_a[0] = 1'b1;
    tick();
    ready_a[0] = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("midfill_busy", 32'(busy_a[0]), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy_a[0]), 32'd0);
    chk("async_rst_mem_re", 32'(re_a[0]), 32'd0);
    chk("async_rst_mem_addr", 32'(maddr_a[0]), 32'd0);
    chk("async_rst_index", 32'(idx_a[0]), 32'd0);
    chk("async_rst_valid", 32'(valid_a[0]), 32'd0);
    for (int k = 0; k < 16; k++) chk($sformatf("async_rst_w%0d", k), data_a[0][k], 32'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("no_block_after_rst", 32'(valid_a[0]), 32'd0);
    end
    chk("no_done_after_rst", 32'(done_cnt_a[0] - dc0), 32'd0);
    run_msg(0, 16'h0100, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
